// File: rtl/ci_fft_feeder.sv
// Boxcar-decimates 12-bit offset-binary ADC samples, converts them to two's complement, queues them and strobes them out spaced >= GAP cycles.
// Latency: group-completing sample to nd is 3 clocks; a full FIFO with no same-cycle pop drops the sample and sets sticky overflow.
module ci_fft_feeder #(
    parameter int DEC_LOG2   = 2,
    parameter int FRAME_LEN  = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        adc_valid,
    input  logic [0:11] adc_data,
    output logic        nd,
    output logic [0:11] data,
    output logic        frame_start,
    output logic        overflow,
    output logic [6:0]  fill_level
);
    localparam int AW = 12 + DEC_LOG2;
    localparam int GW = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FRAME_LEN);
    localparam logic [GW-1:0] GRP_LAST = GW'((1 << DEC_LOG2) - 1);
    localparam logic [7:0]    HOLD_LD  = 8'((GAP > 1) ? GAP - 2 : 0);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    logic [AW-1:0] acc_q, acc_d, sum;
    logic [GW-1:0] grp_q, grp_d;
    logic          dec_vld_q, dec_vld_d;
    logic [11:0]   dec_dat_q, dec_dat_d;

    logic [11:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [6:0]    count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, pop, push_ok;

    state_t        state_q, state_d;
    logic [7:0]    wait_q, wait_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          nd_q, nd_d, fs_q, fs_d;
    logic [11:0]   data_q, data_d;

    assign sum = acc_q + AW'(adc_data);

    always_comb begin
        acc_d     = acc_q;
        grp_d     = grp_q;
        dec_vld_d = 1'b0;
        dec_dat_d = dec_dat_q;
        if (adc_valid) begin
            if (grp_q == GRP_LAST) begin
                acc_d     = '0;
                grp_d     = '0;
                dec_vld_d = 1'b1;
                // Flipping the MSB maps offset-binary onto two's complement.
                dec_dat_d = 12'(sum >> DEC_LOG2) ^ 12'h800;
            end else begin
                acc_d = sum;
                grp_d = grp_q + 1'b1;
            end
        end
    end

    assign empty = (count_q == 7'd0);
    assign full  = (count_q == 7'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        pop     = 1'b0;
        nd_d    = 1'b0;
        fs_d    = 1'b0;
        data_d  = data_q;
        frame_d = frame_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    nd_d    = 1'b1;
                    data_d  = mem_q[rd_q];
                    fs_d    = (frame_q == '0);
                    frame_d = frame_q + 1'b1;
                    if (GAP > 1) begin
                        state_d = S_HOLD;
                        wait_d  = HOLD_LD;
                    end
                end
            end
            S_HOLD: begin
                if (wait_q == 8'd0) state_d = S_IDLE;
                else                wait_d  = wait_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
    assign push_ok = dec_vld_q && (!full || pop);

    always_comb begin
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + 7'd1;
        else if (!push_ok && pop) count_d = count_q - 7'd1;
        ovf_d   = ovf_q | (dec_vld_q & ~push_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= dec_dat_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            grp_q     <= '0;
            dec_vld_q <= 1'b0;
            dec_dat_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            state_q   <= S_IDLE;
            wait_q    <= '0;
            frame_q   <= '0;
            nd_q      <= 1'b0;
            fs_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            acc_q     <= acc_d;
            grp_q     <= grp_d;
            dec_vld_q <= dec_vld_d;
            dec_dat_q <= dec_dat_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            wait_q    <= wait_d;
            frame_q   <= frame_d;
            nd_q      <= nd_d;
            fs_q      <= fs_d;
            data_q    <= data_d;
        end
    end

    assign nd          = nd_q;
    assign data        = data_q;
    assign frame_start = fs_q;
    assign overflow    = ovf_q;
    assign fill_level  = count_q;
endmodule

// File: tb/tb_ci_fft_feeder.sv
// Three feeder configurations share one stimulus stream; a queue-based model predicts every output each cycle,
// and literal expectations pin the directed scenarios.
module tb_ci_fft_feeder;
    localparam int NI = 3;
    localparam int DL [NI] = '{2, 0, 0};
    localparam int GP [NI] = '{4, 4, 1};
    localparam int FLEN  = 64;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        adc_valid;
    logic [11:0] adc_data;
    logic        nd_w   [NI];
    logic [11:0] data_w [NI];
    logic        fs_w   [NI];
    logic        ovf_w  [NI];
    logic [6:0]  fill_w [NI];

    int checks = 0;
    int failures = 0;
    int t = 0;

    int m_acc [NI], m_n [NI], m_pend [NI], m_pval [NI], m_ovf [NI];
    int m_frame [NI], m_last [NI], e_nd [NI], e_data [NI], e_fs [NI];
    int mq [NI][$];
    int lg_d [NI][$];
    int lg_t [NI][$];
    int lg_f [NI][$];
    int maxfill [NI];
    int vin [$];
    int t_e;
    int fs_cnt;

    always #5 clk = ~clk;

    ci_fft_feeder #(.DEC_LOG2(2), .FRAME_LEN(FLEN), .FIFO_DEPTH(DEPTH), .GAP(4)) dut_a (
        .clk(clk), .reset(rst), .adc_valid(adc_valid), .adc_data(adc_data),
        .nd(nd_w[0]), .data(data_w[0]), .frame_start(fs_w[0]), .overflow(ovf_w[0]), .fill_level(fill_w[0]));
    ci_fft_feeder #(.DEC_LOG2(0), .FRAME_LEN(FLEN), .FIFO_DEPTH(DEPTH), .GAP(4)) dut_b (
        .clk(clk), .reset(rst), .adc_valid(adc_valid), .adc_data(adc_data),
        .nd(nd_w[1]), .data(data_w[1]), .frame_start(fs_w[1]), .overflow(ovf_w[1]), .fill_level(fill_w[1]));
    ci_fft_feeder #(.DEC_LOG2(0), .FRAME_LEN(FLEN), .FIFO_DEPTH(DEPTH), .GAP(1)) dut_c (
        .clk(clk), .reset(rst), .adc_valid(adc_valid), .adc_data(adc_data),
        .nd(nd_w[2]), .data(data_w[2]), .frame_start(fs_w[2]), .overflow(ovf_w[2]), .fill_level(fill_w[2]));

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", nm, t, act, exp);
        end
    endfunction

    // Transaction view: pop (if spacing allows) sees only entries pushed at earlier edges,
    // then last edge's completed average is pushed, then this edge's input is accumulated.
    task automatic model_step(int k);
        if (rst) begin
            m_acc[k] = 0; m_n[k] = 0; m_pend[k] = 0; m_ovf[k] = 0; m_frame[k] = 0;
            m_last[k] = -1000; e_nd[k] = 0; e_data[k] = 0; e_fs[k] = 0;
            mq[k].delete();
            return;
        end
        e_nd[k] = 0;
        e_fs[k] = 0;
        if (mq[k].size() > 0 && t - m_last[k] >= GP[k]) begin
            e_data[k]  = mq[k].pop_front();
            e_nd[k]    = 1;
            e_fs[k]    = (m_frame[k] == 0) ? 1 : 0;
            m_frame[k] = (m_frame[k] + 1) % FLEN;
            m_last[k]  = t;
        end
        if (m_pend[k] != 0) begin
            if (mq[k].size() < DEPTH) mq[k].push_back(m_pval[k]);
            else m_ovf[k] = 1;
        end
        m_pend[k] = 0;
        if (adc_valid) begin
            m_acc[k] += int'(adc_data);
            m_n[k]++;
            if (m_n[k] == (1 << DL[k])) begin
                m_pend[k] = 1;
                m_pval[k] = (m_acc[k] >> DL[k]) ^ 'h800;
                m_acc[k]  = 0;
                m_n[k]    = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            t++;
            for (int k = 0; k < NI; k++) begin
                model_step(k);
                chk($sformatf("nd[%0d]", k), int'(nd_w[k]), e_nd[k]);
                chk($sformatf("data[%0d]", k), int'(data_w[k]), e_data[k]);
                chk($sformatf("frame_start[%0d]", k), int'(fs_w[k]), e_fs[k]);
                chk($sformatf("overflow[%0d]", k), int'(ovf_w[k]), m_ovf[k]);
                chk($sformatf("fill_level[%0d]", k), int'(fill_w[k]), mq[k].size());
                if (nd_w[k]) begin
                    lg_d[k].push_back(int'(data_w[k]));
                    lg_t[k].push_back(t);
                    lg_f[k].push_back(int'(fs_w[k]));
                end
                if (int'(fill_w[k]) > maxfill[k]) maxfill[k] = int'(fill_w[k]);
            end
        end
    end

    task automatic cyc(bit v, int d);
        @(negedge clk);
        adc_valid = v;
        adc_data  = d[11:0];
    endtask

    task automatic idle(int n);
        repeat (n) cyc(1'b0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        adc_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        for (int k = 0; k < NI; k++) begin
            lg_d[k].delete();
            lg_t[k].delete();
            lg_f[k].delete();
            maxfill[k] = 0;
        end
    endtask

    initial begin
        rst = 1'b1;
        adc_valid = 1'b0;
        adc_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_nd", int'(nd_w[0]), 0);
        chk("reset_data", int'(data_w[0]), 0);
        chk("reset_overflow", int'(ovf_w[0]), 0);
        chk("reset_fill", int'(fill_w[0]), 0);

        // Averaging at the high end.
        clear_logs();
        cyc(1'b1, 'hFFF); cyc(1'b1, 'hFFF); cyc(1'b1, 'hFFF); cyc(1'b1, 'hFFC);
        t_e = t + 1;
        idle(30);
        chk("avg_count", lg_d[0].size(), 1);
        if (lg_d[0].size() >= 1) begin
            chk("avg_data", lg_d[0][0], 'h7FE);
            chk("avg_frame_start", lg_f[0][0], 1);
            chk("avg_latency", lg_t[0][0] - t_e, 2);
        end

        // Sign conversion.
        do_reset();
        clear_logs();
        repeat (4) cyc(1'b1, 'h800);
        repeat (4) cyc(1'b1, 'h000);
        repeat (4) cyc(1'b1, 'h900);
        idle(40);
        chk("sign_count", lg_d[0].size(), 3);
        if (lg_d[0].size() == 3) begin
            chk("sign_d0", lg_d[0][0], 'h000);
            chk("sign_d1", lg_d[0][1], 'h800);
            chk("sign_d2", lg_d[0][2], 'h100);
            chk("sign_spacing", (lg_t[0][1] - lg_t[0][0] >= 4) ? 1 : 0, 1);
        end

        // Frame marking.
        do_reset();
        clear_logs();
        for (int i = 0; i < 130; i++) begin
            cyc(1'b1, int'($urandom_range(0, 4095)));
            idle(3);
        end
        idle(60);
        chk("frame_nd_count", lg_d[1].size(), 130);
        fs_cnt = 0;
        foreach (lg_f[1][i]) fs_cnt += lg_f[1][i];
        chk("frame_start_count", fs_cnt, 3);
        if (lg_f[1].size() == 130) begin
            chk("frame_start_0", lg_f[1][0], 1);
            chk("frame_start_64", lg_f[1][64], 1);
            chk("frame_start_128", lg_f[1][128], 1);
        end

        // Overflow.
        do_reset();
        clear_logs();
        repeat (40) cyc(1'b1, int'($urandom_range(0, 4095)));
        idle(100);
        chk("ovf_max_fill", maxfill[1], 16);
        chk("ovf_sticky", int'(ovf_w[1]), 1);
        chk("ovf_drained", int'(fill_w[1]), 0);
        chk("ovf_lost", (lg_d[1].size() < 40 && lg_d[1].size() >= 16) ? 1 : 0, 1);
        chk("gap1_no_ovf", int'(ovf_w[2]), 0);
        chk("gap1_all", lg_d[2].size(), 40);

        // Reset mid-group, with instance b still flagging overflow.
        cyc(1'b1, 'h123); cyc(1'b1, 'h456);
        do_reset();
        chk("mid_rst_overflow", int'(ovf_w[1]), 0);
        chk("mid_rst_fill", int'(fill_w[1]), 0);
        clear_logs();
        repeat (4) cyc(1'b1, 'h900);
        idle(30);
        if (lg_d[0].size() >= 1) begin
            chk("mid_rst_data", lg_d[0][0], 'h100);
            chk("mid_rst_frame_start", lg_f[0][0], 1);
        end else chk("mid_rst_count", lg_d[0].size(), 1);

        // Back-to-back burst at GAP=1.
        do_reset();
        clear_logs();
        vin.delete();
        for (int i = 0; i < 5; i++) begin
            vin.push_back(int'($urandom_range(0, 4095)));
            cyc(1'b1, vin[i]);
        end
        idle(20);
        chk("b2b_count", lg_d[2].size(), 5);
        if (lg_d[2].size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("b2b_data%0d", i), lg_d[2][i], vin[i] ^ 'h800);
                chk($sformatf("b2b_time%0d", i), lg_t[2][i] - lg_t[2][0], i);
            end
        end

        // Random traffic with occasional reset.
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            int pct;
            pct = int'($urandom_range(10, 100));
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 299) == 0) do_reset();
                else cyc(($urandom_range(0, 99) < pct), int'($urandom_range(0, 4095)));
            end
        end
        idle(120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
